// File: rtl/clk_div_prog_pkg.sv
// Shared constants for the programmable clock/baud divider family.
// Includes the legacy 2-bit preset map for callers that still select a fixed ratio.
package clk_div_prog_pkg;

    localparam int DIV_MIN = 2;

    localparam int DIV_PRESET_0 = 2;
    localparam int DIV_PRESET_1 = 4;
    localparam int DIV_PRESET_2 = 8;
    localparam int DIV_PRESET_3 = 16;

    function automatic int preset_div(input logic [1:0] sel);
        case (sel)
            2'd0:    return DIV_PRESET_0;
            2'd1:    return DIV_PRESET_1;
            2'd2:    return DIV_PRESET_2;
            default: return DIV_PRESET_3;
        endcase
    endfunction

endpackage

// File: rtl/clk_div_shadow.sv
// Double-buffered divisor: clamps requests, holds a pending value, and acks
// when the divider applies it at a period boundary (or bypasses on that boundary).
module clk_div_shadow
    import clk_div_prog_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             divisor_ld,
    input  logic [WIDTH-1:0] divisor_val,
    input  logic             apply,
    output logic             next_valid,
    output logic [WIDTH-1:0] next_div,
    output logic             pending,
    output logic             ld_ack
);

    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             ld_ack_q, ld_ack_d;
    logic [WIDTH-1:0] val_clamped;

    assign val_clamped = (divisor_val < WIDTH'(DIV_MIN)) ? WIDTH'(DIV_MIN) : divisor_val;

    // A load arriving on the apply cycle overrides any older shadow value.
    assign next_valid = divisor_ld | pending_q;
    assign next_div   = divisor_ld ? val_clamped : shadow_q;

    always_comb begin
        shadow_d  = shadow_q;
        pending_d = pending_q;
        ld_ack_d  = 1'b0;
        if (divisor_ld) begin
            shadow_d = val_clamped;
        end
        if (apply) begin
            pending_d = 1'b0;
            ld_ack_d  = next_valid;
        end else if (divisor_ld) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            shadow_q  <= WIDTH'(DEFAULT_DIV);
            pending_q <= 1'b0;
            ld_ack_q  <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            ld_ack_q  <= ld_ack_d;
        end
    end

    assign pending = pending_q;
    assign ld_ack  = ld_ack_q;

endmodule

// File: rtl/clk_div_prog.sv
// Programmable integer clock/baud divider with ~50% clk_out, rise/mid ticks,
// glitch-free divisor changes at period boundaries and a start-bit restart.
module clk_div_prog
    import clk_div_prog_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic             divisor_ld,
    input  logic [WIDTH-1:0] divisor_val,
    output logic             clk_out,
    output logic             tick_rise,
    output logic             tick_mid,
    output logic             ld_ack,
    output logic             busy,
    output logic [WIDTH-1:0] divisor_cur
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] d_act_q, d_act_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_rise_q, tick_rise_d;
    logic             tick_mid_q, tick_mid_d;

    logic             wrap;
    logic             apply;
    logic             next_valid;
    logic [WIDTH-1:0] next_div;
    logic [WIDTH-1:0] d_new;
    logic [WIDTH-1:0] half;

    assign wrap  = (cnt_q == d_act_q - WIDTH'(1));
    assign apply = restart | (en & wrap);

    clk_div_shadow #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_shadow (
        .clk_in      (clk_in),
        .rst         (rst),
        .divisor_ld  (divisor_ld),
        .divisor_val (divisor_val),
        .apply       (apply),
        .next_valid  (next_valid),
        .next_div    (next_div),
        .pending     (busy),
        .ld_ack      (ld_ack)
    );

    // Divisor in force for the period that starts (or continues) after this edge.
    assign d_new = (apply && next_valid) ? next_div : d_act_q;
    assign half  = d_new >> 1;

    always_comb begin
        cnt_d       = cnt_q;
        d_act_d     = d_act_q;
        clk_out_d   = clk_out_q;
        tick_rise_d = 1'b0;
        tick_mid_d  = 1'b0;
        if (restart) begin
            // Park on the last count so the next enabled edge opens a fresh period.
            cnt_d     = d_new - WIDTH'(1);
            d_act_d   = d_new;
            clk_out_d = 1'b0;
        end else if (en) begin
            cnt_d       = wrap ? '0 : cnt_q + WIDTH'(1);
            d_act_d     = d_new;
            clk_out_d   = (cnt_d < half);
            tick_rise_d = (cnt_d == '0);
            tick_mid_d  = (cnt_d == half);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q       <= WIDTH'(DEFAULT_DIV - 1);
            d_act_q     <= WIDTH'(DEFAULT_DIV);
            clk_out_q   <= 1'b0;
            tick_rise_q <= 1'b0;
            tick_mid_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            d_act_q     <= d_act_d;
            clk_out_q   <= clk_out_d;
            tick_rise_q <= tick_rise_d;
            tick_mid_q  <= tick_mid_d;
        end
    end

    assign clk_out     = clk_out_q;
    assign tick_rise   = tick_rise_q;
    assign tick_mid    = tick_mid_q;
    assign divisor_cur = d_act_q;

endmodule
